// File: rtl/gerenciador_vidas_pkg.sv
// Shared definitions for the life manager.
//  - state_t: FSM state encoding (ALIVE=0, INVULN=1, GAME_OVER=2)
//  - timer_w: width needed to hold INVULN_CYCLES (clog2(cycles+1), at least 1)
package gerenciador_vidas_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  // Bits needed to store the values 0..cycles. The result is never below 1,
  // so that a build with no invulnerability window still has a valid vector.
  function automatic int timer_w(input int cycles);
    int w;
    w = 1;
    while ((1 << w) < (cycles + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/gerenciador_vidas_temporizador_invuln.sv
// Loadable down-counter that times the post-hit invulnerability window.
// Ports:
//  clock       in   rising-edge clock
//  reset       in   synchronous, active-low; clears the count
//  load        in   load load_value this cycle (has priority over counting)
//  load_value  in   W-bit value to load
//  value       out  W-bit current count
//  expired     out  high while the count is 1, i.e. during the last cycle of the window
module temporizador_invuln #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign value   = count;
  assign expired = (count == W'(1));

endmodule

// File: rtl/gerenciador_vidas.sv
// Player life manager: holds the life count, decrements on hits, grants extra
// lives, enforces a post-hit invulnerability window and flags game over.
// Configuration macro: VIDA_EXTRA_EN -- when defined, bonus pulses add a life
// (saturating at MAX_LIVES); when undefined, bonus is ignored.
// Ports:
//  clock        in   rising-edge clock
//  reset        in   synchronous, active-low reset
//  hit          in   1-cycle pulse: player was hit
//  bonus        in   1-cycle pulse: extra life awarded
//  restart      in   1-cycle pulse: start a new game
//  lives        out  LIVES_W current life count (registered)
//  game_over    out  high while in GAME_OVER
//  invulnerable out  high while in INVULN
//  life_lost    out  1-cycle pulse the cycle after an accepted hit
module gerenciador_vidas
  import gerenciador_vidas_pkg::*;
#(
  parameter int LIVES_W       = 3,
  parameter int MAX_LIVES     = 5,
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_CYCLES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hit,
  input  logic               bonus,
  input  logic               restart,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               invulnerable,
  output logic               life_lost
);

  localparam int TW = timer_w(INVULN_CYCLES);
  localparam logic [LIVES_W-1:0] MAX_L  = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] INIT_L = LIVES_W'(INIT_LIVES);

  state_t        state;
  logic          bonus_en;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_value;
  logic [TW-1:0] timer_value;
  logic          tmr_expired;
  logic          unused_timer_bits;

`ifdef VIDA_EXTRA_EN
  assign bonus_en = bonus;
`else
  logic unused_bonus;
  assign unused_bonus = bonus;
  assign bonus_en     = 1'b0;
`endif

  // The count is only consumed through the expired flag.
  assign unused_timer_bits = ^timer_value;

  // Restart clears the timer so a pending window is abandoned; an accepted
  // non-fatal hit arms it.
  always_comb begin
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    if (restart) begin
      tmr_load = 1'b1;
    end else if ((state == ALIVE) && hit && (lives > LIVES_W'(1)) && (INVULN_CYCLES > 0)) begin
      tmr_load       = 1'b1;
      tmr_load_value = TW'(INVULN_CYCLES);
    end
  end

  temporizador_invuln #(.W(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (timer_value),
    .expired    (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ALIVE;
      lives        <= INIT_L;
      game_over    <= 1'b0;
      invulnerable <= 1'b0;
      life_lost    <= 1'b0;
    end else begin
      life_lost <= 1'b0;
      if (restart) begin
        state        <= ALIVE;
        lives        <= INIT_L;
        game_over    <= 1'b0;
        invulnerable <= 1'b0;
      end else begin
        case (state)
          ALIVE: begin
            // A hit takes precedence over a simultaneous bonus.
            if (hit) begin
              life_lost <= 1'b1;
              if (lives > LIVES_W'(1)) begin
                lives <= lives - LIVES_W'(1);
                if (INVULN_CYCLES > 0) begin
                  state        <= INVULN;
                  invulnerable <= 1'b1;
                end
              end else begin
                lives     <= '0;
                state     <= GAME_OVER;
                game_over <= 1'b1;
              end
            end else if (bonus_en && (lives < MAX_L)) begin
              lives <= lives + LIVES_W'(1);
            end
          end
          INVULN: begin
            if (bonus_en && (lives < MAX_L)) begin
              lives <= lives + LIVES_W'(1);
            end
            if (tmr_expired) begin
              state        <= ALIVE;
              invulnerable <= 1'b0;
            end
          end
          GAME_OVER: begin
            lives <= '0;
          end
          default: begin
            state        <= ALIVE;
            lives        <= INIT_L;
            game_over    <= 1'b0;
            invulnerable <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gerenciador_vidas.sv
// Self-checking bench for gerenciador_vidas. Two instances: the default
// configuration (d0) and one with no invulnerability window and a 4-bit count
// (d1). Each scheduled cycle carries its stimulus and the outputs expected
// after the following rising edge.
module tb_gerenciador_vidas;

`ifdef VIDA_EXTRA_EN
  localparam bit EXTRA = 1'b1;
`else
  localparam bit EXTRA = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst0 = 1'b1, hit0 = 1'b0, bonus0 = 1'b0, restart0 = 1'b0;
  logic       rst1 = 1'b1, hit1 = 1'b0, bonus1 = 1'b0, restart1 = 1'b0;
  logic [2:0] lives0;
  logic [3:0] lives1;
  logic       go0, inv0, lost0, go1, inv1, lost1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gerenciador_vidas dut0 (
    .clock(clk), .reset(rst0), .hit(hit0), .bonus(bonus0), .restart(restart0),
    .lives(lives0), .game_over(go0), .invulnerable(inv0), .life_lost(lost0)
  );

  gerenciador_vidas #(.LIVES_W(4), .MAX_LIVES(15), .INIT_LIVES(3), .INVULN_CYCLES(0)) dut1 (
    .clock(clk), .reset(rst1), .hit(hit1), .bonus(bonus1), .restart(restart1),
    .lives(lives1), .game_over(go1), .invulnerable(inv1), .life_lost(lost1)
  );

  typedef struct {
    bit         sel;
    logic       rst_n, hit, bonus, restart;
    logic [6:0] exp;   // {lives[3:0], game_over, invulnerable, life_lost}
  } step_t;

  step_t sb[$];

  function automatic void push(bit sel, logic rst_n, logic h, logic b, logic r,
                               int lv, logic go, logic inv, logic lost);
    step_t s;
    s.sel = sel; s.rst_n = rst_n; s.hit = h; s.bonus = b; s.restart = r;
    s.exp = {4'(lv), go, inv, lost};
    sb.push_back(s);
  endfunction

  function automatic logic [6:0] observed(bit sel);
    return sel ? {lives1, go1, inv1, lost1} : {1'b0, lives0, go0, inv0, lost0};
  endfunction

  // Pops the next scheduled cycle, drives it, and returns once the outputs of
  // the resulting edge are stable.
  task automatic apply_next(output step_t s);
    s = sb.pop_front();
    if (s.sel) begin
      rst1 = s.rst_n; hit1 = s.hit; bonus1 = s.bonus; restart1 = s.restart;
    end else begin
      rst0 = s.rst_n; hit0 = s.hit; bonus0 = s.bonus; restart0 = s.restart;
    end
    @(posedge clk);
    #1;
    rst0 = 1'b1; hit0 = 1'b0; bonus0 = 1'b0; restart0 = 1'b0;
    rst1 = 1'b1; hit1 = 1'b0; bonus1 = 1'b0; restart1 = 1'b0;
  endtask

  task automatic test_reset();
    step_t s;
    int k = 0;
    push(0, 0, 0, 0, 0, 3, 0, 0, 0);
    push(0, 1, 0, 0, 0, 3, 0, 0, 0);
    while (sb.size() > 0) begin
      apply_next(s);
      checks++;
      if (observed(s.sel) !== s.exp)
        $display("FAIL reset[%0d]: got %b expected %b", k, observed(s.sel), s.exp);
      else passed++;
      k++;
    end
  endtask

  task automatic test_invuln_window();
    step_t s;
    int k = 0;
    push(0, 1, 1, 0, 0, 2, 0, 1, 1);
    for (int i = 1; i <= 7; i++) push(0, 1, 1, 0, 0, 2, 0, 1, 0);
    push(0, 1, 0, 0, 0, 2, 0, 0, 0);
    push(0, 1, 0, 0, 0, 2, 0, 0, 0);
    push(0, 1, 0, 0, 1, 3, 0, 0, 0);
    while (sb.size() > 0) begin
      apply_next(s);
      checks++;
      if (observed(s.sel) !== s.exp)
        $display("FAIL invuln_window[%0d]: got %b expected %b", k, observed(s.sel), s.exp);
      else passed++;
      k++;
    end
  endtask

  task automatic test_game_over();
    step_t s;
    int k = 0;
    for (int h = 2; h >= 1; h--) begin
      push(0, 1, 1, 0, 0, h, 0, 1, 1);
      for (int i = 1; i <= 7; i++) push(0, 1, 0, 0, 0, h, 0, 1, 0);
      push(0, 1, 0, 0, 0, h, 0, 0, 0);
    end
    push(0, 1, 1, 0, 0, 0, 1, 0, 1);
    push(0, 1, 1, 0, 0, 0, 1, 0, 0);
    push(0, 1, 0, 1, 0, 0, 1, 0, 0);
    push(0, 1, 1, 1, 0, 0, 1, 0, 0);
    push(0, 1, 0, 0, 1, 3, 0, 0, 0);
    while (sb.size() > 0) begin
      apply_next(s);
      checks++;
      if (observed(s.sel) !== s.exp)
        $display("FAIL game_over[%0d]: got %b expected %b", k, observed(s.sel), s.exp);
      else passed++;
      k++;
    end
  endtask

  task automatic test_bonus();
    step_t s;
    int k = 0;
    int lv = 3;
    for (int i = 0; i < 4; i++) begin
      if (EXTRA && lv < 5) lv++;
      push(0, 1, 0, 1, 0, lv, 0, 0, 0);
    end
    lv--;                                    // hit wins over bonus in ALIVE
    push(0, 1, 1, 1, 0, lv, 0, 1, 1);
    if (EXTRA && lv < 5) lv++;               // in INVULN: hit ignored, bonus applied
    push(0, 1, 1, 1, 0, lv, 0, 1, 0);
    for (int i = 2; i <= 7; i++) push(0, 1, 0, 0, 0, lv, 0, 1, 0);
    push(0, 1, 0, 0, 0, lv, 0, 0, 0);
    push(0, 1, 0, 0, 1, 3, 0, 0, 0);
    while (sb.size() > 0) begin
      apply_next(s);
      checks++;
      if (observed(s.sel) !== s.exp)
        $display("FAIL bonus[%0d]: got %b expected %b", k, observed(s.sel), s.exp);
      else passed++;
      k++;
    end
  endtask

  task automatic test_abort_window();
    step_t s;
    int k = 0;
    push(0, 1, 1, 0, 0, 2, 0, 1, 1);
    push(0, 1, 0, 0, 0, 2, 0, 1, 0);
    push(0, 1, 0, 0, 0, 2, 0, 1, 0);
    push(0, 0, 0, 0, 0, 3, 0, 0, 0);          // reset in window cycle 3
    push(0, 1, 0, 0, 0, 3, 0, 0, 0);
    push(0, 1, 1, 0, 1, 3, 0, 0, 0);          // restart overrides hit
    push(0, 1, 1, 0, 0, 2, 0, 1, 1);
    push(0, 1, 0, 0, 1, 3, 0, 0, 0);          // restart aborts window
    push(0, 1, 0, 0, 0, 3, 0, 0, 0);
    push(0, 0, 1, 0, 1, 3, 0, 0, 0);          // reset overrides restart and hit
    while (sb.size() > 0) begin
      apply_next(s);
      checks++;
      if (observed(s.sel) !== s.exp)
        $display("FAIL abort_window[%0d]: got %b expected %b", k, observed(s.sel), s.exp);
      else passed++;
      k++;
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    int k = 0;
    push(1, 0, 0, 0, 0, 3, 0, 0, 0);
    push(1, 1, 1, 0, 0, 2, 0, 0, 1);
    push(1, 1, 1, 0, 0, 1, 0, 0, 1);
    push(1, 1, 1, 0, 0, 0, 1, 0, 1);
    push(1, 1, 1, 0, 0, 0, 1, 0, 0);
    push(1, 1, 0, 0, 1, 3, 0, 0, 0);
    push(1, 1, 1, 0, 0, 2, 0, 0, 1);
    push(1, 1, 0, 0, 0, 2, 0, 0, 0);
    while (sb.size() > 0) begin
      apply_next(s);
      checks++;
      if (observed(s.sel) !== s.exp)
        $display("FAIL back_to_back[%0d]: got %b expected %b", k, observed(s.sel), s.exp);
      else passed++;
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_invuln_window();
    test_game_over();
    test_bonus();
    test_abort_window();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
